// File: rtl/ocimem_debug_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG ocimem commands and an
// Avalon-MM debug port, with round-robin arbitration between the two sides.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no RAM access; arbitrate JTAG command slot vs Avalon request
// JWR   | JTAG write of MonDReg to RAM[MonAReg]
// JRD   | JTAG read of RAM[MonAReg] issued
// JCAP  | JTAG read data captured into MonDReg
// AWR   | Avalon write, waitrequest released
// ARD   | Avalon read issued
// ACAP  | Avalon read data passed through, waitrequest released
module ocimem_debug_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [37:0]       jdo,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_JWR,
        S_JRD,
        S_JCAP,
        S_AWR,
        S_ARD,
        S_ACAP
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_mon_a;
    logic [31:0]         r_mon_d;
    logic                r_jpend;
    logic                r_jop_wr;
    logic                r_last_j;
    logic                r_err;

    logic                w_sel_a;
    logic                w_sel_n;
    logic                w_sel_b;
    logic                w_strobe;
    logic                w_jclr;
    logic                w_accept;
    logic                w_new_req;
    logic                w_err_set;
    logic                w_err_clr;
    logic                w_jreq;
    logic                w_jwr;
    logic                w_areq;
    logic                w_grant_j;
    logic                w_grant_a;
    logic                w_unused_jdo;

    // Strobe priority: ocimem_b over ocimem_a over no_action_ocimem_a.
    assign w_sel_b  = take_action_ocimem_b;
    assign w_sel_a  = take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_sel_n  = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_strobe = w_sel_a | w_sel_n | w_sel_b;

    // The slot frees in JWR/JCAP, so a strobe landing there is still taken.
    assign w_jclr    = (r_state == S_JWR) || (r_state == S_JCAP);
    assign w_accept  = w_strobe & (~r_jpend | w_jclr);
    assign w_new_req = w_accept & (w_sel_b | w_sel_n | (w_sel_a & jdo[34]));
    assign w_err_set = w_strobe & ~w_accept;
    assign w_err_clr = w_sel_a & jdo[35];

    // A freshly accepted strobe competes in the same cycle it arrives.
    assign w_jreq    = r_jpend | w_new_req;
    assign w_jwr     = r_jpend ? r_jop_wr : w_sel_b;
    assign w_areq    = av_read | av_write;
    assign w_grant_j = w_jreq & (~w_areq | ~r_last_j);
    assign w_grant_a = w_areq & ~w_grant_j;

    assign w_unused_jdo = ^{jdo[37:36], jdo[2:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        av_readdata    = '0;
        av_waitrequest = w_areq;
        case (r_state)
            S_IDLE: begin
                if (w_grant_j) begin
                    w_next = w_jwr ? S_JWR : S_JRD;
                end else if (w_grant_a) begin
                    w_next = av_write ? S_AWR : S_ARD;
                end
            end
            S_JWR: begin
                mem_wr    = 1'b1;
                mem_addr  = r_mon_a;
                mem_wdata = r_mon_d;
                w_next    = S_IDLE;
            end
            S_JRD: begin
                mem_rd   = 1'b1;
                mem_addr = r_mon_a;
                w_next   = S_JCAP;
            end
            S_JCAP: begin
                w_next = S_IDLE;
            end
            S_AWR: begin
                mem_wr         = 1'b1;
                mem_addr       = av_address;
                mem_wdata      = av_writedata;
                av_waitrequest = 1'b0;
                w_next         = S_IDLE;
            end
            S_ARD: begin
                mem_rd   = 1'b1;
                mem_addr = av_address;
                w_next   = S_ACAP;
            end
            S_ACAP: begin
                av_readdata    = mem_rdata;
                av_waitrequest = 1'b0;
                w_next         = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mon_a  <= '0;
            r_mon_d  <= '0;
            r_jpend  <= 1'b0;
            r_jop_wr <= 1'b0;
            r_last_j <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // A new address load wins over the post-access increment.
            if (w_accept && w_sel_a) begin
                r_mon_a <= jdo[17 +: ADDR_W];
            end else if (w_jclr) begin
                r_mon_a <= r_mon_a + {{(ADDR_W-1){1'b0}}, 1'b1};
            end

            if (w_accept && w_sel_b) begin
                r_mon_d <= jdo[34:3];
            end else if (r_state == S_JCAP) begin
                r_mon_d <= mem_rdata;
            end

            if (w_new_req) begin
                r_jpend  <= 1'b1;
                r_jop_wr <= w_sel_b;
            end else if (w_jclr) begin
                r_jpend <= 1'b0;
            end

            if (r_state == S_IDLE) begin
                if (w_grant_j) begin
                    r_last_j <= 1'b1;
                end else if (w_grant_a) begin
                    r_last_j <= 1'b0;
                end
            end

            if (w_err_clr) begin
                r_err <= 1'b0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign MonDReg       = r_mon_d;
    assign monitor_ready = ~r_jpend;
    assign monitor_error = r_err;

endmodule

// File: tb/tb_ocimem_debug_arbiter.sv
// Directed bench for ocimem_debug_arbiter: a transaction table plus
// hand-written sequences for arbitration, overrun, slot reuse and reset abort.
module tb_ocimem_debug_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          take_action_ocimem_a;
    logic          take_no_action_ocimem_a;
    logic          take_action_ocimem_b;
    logic [37:0]   jdo;
    logic [AW-1:0] av_address;
    logic          av_read;
    logic          av_write;
    logic [31:0]   av_writedata;
    logic [31:0]   av_readdata;
    logic          av_waitrequest;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   MonDReg;
    logic          monitor_ready;
    logic          monitor_error;

    always #5 clk = ~clk;

    ocimem_debug_arbiter #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .jdo                     (jdo),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .mem_addr                (mem_addr),
        .mem_rd                  (mem_rd),
        .mem_wr                  (mem_wr),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // RAM model: preloaded with A50000xx, except 0x10 = DEADBEEF.
    logic [31:0] ram [256];
    logic        ram_ready;
    logic [7:0]  last_addr;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++)
                ram[i] <= (i == 16) ? 32'hDEADBEEF : (32'hA5000000 | i);
        end else if (mem_wr) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (mem_rd) mem_rdata <= ram[mem_addr];
        if (mem_rd || mem_wr) last_addr <= mem_addr;
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] jd_addr(input logic [7:0] a, input bit rd, input bit clr);
        logic [37:0] j;
        j = '0;
        j[24:17] = a;
        j[34] = rd;
        j[35] = clr;
        return j;
    endfunction

    function automatic logic [37:0] jd_data(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    // kind: 0 = ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b
    task automatic jdrive(input int kind, input logic [37:0] d);
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        jdo = d;
    endtask

    task automatic jclear();
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        jdo = '0;
    endtask

    task automatic jstrobe(input int kind, input logic [37:0] d);
        jdrive(kind, d);
        @(posedge clk); #1;
        jclear();
    endtask

    task automatic jwait(output int lat);
        lat = 1;
        while (!monitor_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic av_xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd);
        av_address   = a;
        av_writedata = d;
        av_write     = wr;
        av_read      = !wr;
        #1;
        chk("av_stall_first", {31'b0, av_waitrequest}, 32'd1);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (av_waitrequest && lat < 20);
        rd = av_readdata;
        @(posedge clk); #1;
        chk("av_stall_after", {31'b0, av_waitrequest}, 32'd1);
        av_read  = 1'b0;
        av_write = 1'b0;
    endtask

    typedef enum logic [2:0] {OP_AVW, OP_AVR, OP_JLD, OP_JLDRD, OP_JNXT, OP_JWR} op_e;
    typedef struct {
        op_e         op;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic [7:0]  exp_addr;
        int          exp_lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        logic [31:0] rd;

        reset_n = 1'b0;
        ram_ready = 1'b0;
        jclear();
        av_address = '0;
        av_read = 1'b0;
        av_write = 1'b0;
        av_writedata = '0;

        vecs[0]  = '{OP_JLDRD, 8'h10, 32'h0,        32'hDEADBEEF, 8'h10, 3};
        vecs[1]  = '{OP_JNXT,  8'h00, 32'h0,        32'hA5000011, 8'h11, 3};
        vecs[2]  = '{OP_JLD,   8'hFF, 32'h0,        32'hA5000011, 8'h00, 1};
        vecs[3]  = '{OP_JWR,   8'h00, 32'h12345678, 32'h12345678, 8'hFF, 2};
        vecs[4]  = '{OP_JNXT,  8'h00, 32'h0,        32'hA5000000, 8'h00, 3};
        vecs[5]  = '{OP_AVW,   8'h00, 32'h11110000, 32'h0,        8'h00, 1};
        vecs[6]  = '{OP_AVW,   8'h01, 32'h22220001, 32'h0,        8'h01, 1};
        vecs[7]  = '{OP_AVW,   8'h02, 32'h33330002, 32'h0,        8'h02, 1};
        vecs[8]  = '{OP_AVW,   8'h03, 32'h44440003, 32'h0,        8'h03, 1};
        vecs[9]  = '{OP_AVR,   8'h02, 32'h0,        32'h33330002, 8'h02, 2};
        vecs[10] = '{OP_AVR,   8'h20, 32'h0,        32'hA5000020, 8'h20, 2};
        vecs[11] = '{OP_JWR,   8'h00, 32'hCAFEF00D, 32'hCAFEF00D, 8'h01, 2};
        vecs[12] = '{OP_JNXT,  8'h00, 32'h0,        32'h33330002, 8'h02, 3};

        repeat (3) @(posedge clk);
        #1;
        ram_ready = 1'b1;

        chk("rst_ready",   {31'b0, monitor_ready}, 32'd1);
        chk("rst_error",   {31'b0, monitor_error}, 32'd0);
        chk("rst_monD",    MonDReg, 32'd0);
        chk("rst_mem_rd",  {31'b0, mem_rd}, 32'd0);
        chk("rst_mem_wr",  {31'b0, mem_wr}, 32'd0);
        chk("rst_mem_adr", {24'b0, mem_addr}, 32'd0);
        chk("rst_mem_wd",  mem_wdata, 32'd0);
        chk("rst_av_rd",   av_readdata, 32'd0);
        chk("rst_av_wait", {31'b0, av_waitrequest}, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < NV; k++) begin
            case (vecs[k].op)
                OP_AVW, OP_AVR: begin
                    av_xfer(vecs[k].op == OP_AVW, vecs[k].addr, vecs[k].data, lat, rd);
                    chk($sformatf("v%0d_lat", k), lat, vecs[k].exp_lat);
                    chk($sformatf("v%0d_addr", k), {24'b0, last_addr}, {24'b0, vecs[k].exp_addr});
                    if (vecs[k].op == OP_AVW)
                        chk($sformatf("v%0d_ram", k), ram[vecs[k].exp_addr], vecs[k].data);
                    else
                        chk($sformatf("v%0d_rdata", k), rd, vecs[k].exp_data);
                end
                default: begin
                    case (vecs[k].op)
                        OP_JLD:   jstrobe(0, jd_addr(vecs[k].addr, 1'b0, 1'b0));
                        OP_JLDRD: jstrobe(0, jd_addr(vecs[k].addr, 1'b1, 1'b0));
                        OP_JNXT:  jstrobe(1, '0);
                        default:  jstrobe(2, jd_data(vecs[k].data));
                    endcase
                    jwait(lat);
                    chk($sformatf("v%0d_lat", k), lat, vecs[k].exp_lat);
                    chk($sformatf("v%0d_monD", k), MonDReg, vecs[k].exp_data);
                    if (vecs[k].op != OP_JLD)
                        chk($sformatf("v%0d_addr", k), {24'b0, last_addr}, {24'b0, vecs[k].exp_addr});
                    if (vecs[k].op == OP_JWR)
                        chk($sformatf("v%0d_ram", k), ram[vecs[k].exp_addr], vecs[k].data);
                end
            endcase
        end
        chk("no_error_so_far", {31'b0, monitor_error}, 32'd0);

        // Both sides request with JTAG served last: Avalon goes first.
        jstrobe(0, jd_addr(8'h30, 1'b0, 1'b0));
        jdrive(1, '0);
        av_address = 8'h20;
        av_read = 1'b1;
        @(posedge clk); #1;
        jclear();
        chk("arb_av_rd",    {31'b0, mem_rd}, 32'd1);
        chk("arb_av_addr",  {24'b0, mem_addr}, 32'h20);
        chk("arb_j_pend",   {31'b0, monitor_ready}, 32'd0);
        chk("arb_av_wait1", {31'b0, av_waitrequest}, 32'd1);
        @(posedge clk); #1;
        chk("arb_av_wait2", {31'b0, av_waitrequest}, 32'd0);
        chk("arb_av_data",  av_readdata, 32'hA5000020);
        @(posedge clk); #1;
        av_read = 1'b0;
        n = 0;
        while (!mem_rd && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("arb_j_delay", n, 1);
        chk("arb_j_addr",  {24'b0, mem_addr}, 32'h30);
        jwait(lat);
        chk("arb_j_data",  MonDReg, 32'hA5000030);

        // Overrun: strobes while the slot is busy are dropped.
        jdrive(0, jd_addr(8'h40, 1'b1, 1'b0));
        @(posedge clk); #1;
        jdrive(0, jd_addr(8'h77, 1'b1, 1'b0));
        @(posedge clk); #1;
        jclear();
        chk("ovr_err_set", {31'b0, monitor_error}, 32'd1);
        jwait(lat);
        chk("ovr_rd_data", MonDReg, 32'hA5000040);
        jdrive(1, '0);
        @(posedge clk); #1;
        jdrive(2, jd_data(32'h99999999));
        @(posedge clk); #1;
        jclear();
        chk("ovr_monD_kept", MonDReg, 32'hA5000040);
        jwait(lat);
        chk("ovr_addr_kept", {24'b0, last_addr}, 32'h41);
        chk("ovr_next_data", MonDReg, 32'hA5000041);
        chk("ovr_sticky", {31'b0, monitor_error}, 32'd1);
        jstrobe(0, jd_addr(8'h00, 1'b0, 1'b1));
        chk("ovr_err_clr", {31'b0, monitor_error}, 32'd0);

        // Strobe in the JCAP cycle, when the slot frees, is accepted.
        jstrobe(0, jd_addr(8'h50, 1'b1, 1'b0));
        @(posedge clk); #1;
        jdrive(1, '0);
        @(posedge clk); #1;
        jclear();
        chk("reuse_no_err", {31'b0, monitor_error}, 32'd0);
        chk("reuse_data1",  MonDReg, 32'hA5000050);
        chk("reuse_pend",   {31'b0, monitor_ready}, 32'd0);
        jwait(lat);
        chk("reuse_lat",   lat, 4);
        chk("reuse_addr",  {24'b0, last_addr}, 32'h51);
        chk("reuse_data2", MonDReg, 32'hA5000051);

        // Reset in the middle of a JTAG read aborts it at once.
        jstrobe(0, jd_addr(8'h60, 1'b1, 1'b0));
        chk("abort_in_jrd", {31'b0, mem_rd}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_rd_drop", {31'b0, mem_rd}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", {31'b0, monitor_ready}, 32'd1);
        chk("abort_monD",  MonDReg, 32'd0);
        chk("abort_err",   {31'b0, monitor_error}, 32'd0);
        chk("abort_rd",    {31'b0, mem_rd}, 32'd0);
        chk("abort_addr",  {24'b0, mem_addr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/ocimem_debug_arbiter.md
# ocimem_debug_arbiter

Sequences debug-monitor accesses to the Nios II on-chip debug memory (OCI RAM) and shares that single-port RAM between two requesters: the JTAG debug slave's command strobes and a system-side Avalon-MM debug port. It decodes the JTAG ocimem strobes and their `jdo` payload into single-word RAM reads and writes, and returns read data through `MonDReg`. It drives `monitor_ready` and `monitor_error` back to the JTAG side and arbitrates fairly against Avalon traffic. It sits between the debug slave wrapper's sysclk outputs and the OCI RAM in the CPU debug subsystem.

## Interface
Parameters:
- `ADDR_W`, default 8: OCI RAM word-address width.

Ports (reset is asynchronous, active-low; single clock domain):
- `clk` in 1: system clock. All logic is rising-edge.
- `reset_n` in 1: asynchronous active-low reset.
- `take_action_ocimem_a` in 1: JTAG load-address strobe, one cycle wide.
- `take_no_action_ocimem_a` in 1: JTAG read-next strobe, one cycle wide.
- `take_action_ocimem_b` in 1: JTAG write-data strobe, one cycle wide.
- `jdo` in 38: JTAG data payload. Sampled only on a strobe cycle.
- `av_address` in ADDR_W: Avalon word address.
- `av_read` in 1: Avalon read request.
- `av_write` in 1: Avalon write request.
- `av_writedata` in 32: Avalon write data.
- `av_readdata` out 32: Avalon read data. Valid when `av_read` is high and `av_waitrequest` is low.
- `av_waitrequest` out 1: Avalon stall.
- `mem_addr` out ADDR_W: RAM address.
- `mem_rd` out 1: RAM read enable. Read data is valid one cycle later.
- `mem_wr` out 1: RAM write enable.
- `mem_wdata` out 32: RAM write data.
- `mem_rdata` in 32: RAM read data.
- `MonDReg` out 32: JTAG data register, returned to the debug slave.
- `monitor_ready` out 1: high when no JTAG command is pending.
- `monitor_error` out 1: sticky overrun flag.

## Operation
- Internal registers:
  - `MonAReg` [ADDR_W-1:0], the JTAG address pointer.
  - `jpend`, a single-entry JTAG command slot holding the op (rd/wr).
  - `last_j`, the round-robin flag.
- JTAG decode, on a strobe cycle:
  - `take_action_ocimem_a`: `MonAReg <= jdo[17+ADDR_W-1:17]`. If `jdo[34]`=1, set `jpend` = rd.
  - `take_no_action_ocimem_a`: set `jpend` = rd at the current `MonAReg`.
  - `take_action_ocimem_b`: `MonDReg <= jdo[34:3]` and set `jpend` = wr.
- Strobe while `jpend` is set: the command is dropped, `monitor_error` is set, and `MonAReg`/`MonDReg` are unchanged.
  - `monitor_error` is cleared only by a `take_action_ocimem_a` strobe with `jdo[35]`=1. The clear takes priority over a set in the same cycle.
- Multiple strobes in one cycle: priority is `ocimem_b` > `ocimem_a` > `no_action_ocimem_a`.
- `monitor_ready` = `~jpend`, registered.
- FSM states:
  - IDLE → JWR: `jpend`=wr and granted.
  - IDLE → JRD: `jpend`=rd and granted.
  - IDLE → AWR: `av_write` and granted.
  - IDLE → ARD: `av_read` and granted.
  - JRD → JCAP.
  - ARD → ACAP.
  - JWR, AWR, JCAP, ACAP → IDLE.
- Arbitration in IDLE:
  - Only one side requesting: that side wins.
  - Both requesting: the side not served last wins.
  - Every grant updates `last_j`.
  - `av_read` and `av_write` both high: treated as write.
- JWR:
  - `mem_wr`=1, `mem_addr`=`MonAReg`, `mem_wdata`=`MonDReg`.
  - On exit, `MonAReg` += 1, wrapping `2^ADDR_W-1` → 0, and `jpend` clears.
- JRD: `mem_rd`=1, `mem_addr`=`MonAReg`.
- JCAP: `MonDReg <= mem_rdata`, `MonAReg` += 1 (same wrap), `jpend` clears.
- AWR: `mem_wr`=1, `mem_addr`=`av_address`, `mem_wdata`=`av_writedata`, `av_waitrequest`=0.
- ARD: `mem_rd`=1, `mem_addr`=`av_address`.
- ACAP: `av_readdata` = `mem_rdata` (combinational pass-through), `av_waitrequest`=0.
- `av_waitrequest` = `(av_read|av_write)` & ~(state ∈ {AWR, ACAP}). It is combinational and is 0 when there is no request.
- Avalon inputs must be held stable while `av_waitrequest`=1. The block does not latch them.

## Timing
- Reset values:
  - FSM = IDLE.
  - `MonAReg`, `MonDReg`, `jpend`, `last_j` = 0.
  - `monitor_error`=0, `monitor_ready`=1.
  - `mem_rd`=`mem_wr`=0, `mem_addr`=`mem_wdata`=0.
  - `av_readdata`=0.
- `mem_*` outputs are decoded from the state register. They are glitch-free and valid the whole state cycle.
- JTAG timing, counted from the strobe at cycle T:
  - `jpend` is set at T+1.
  - Write: JWR at the earliest at T+1; `monitor_ready` returns to 1 at T+2.
  - Read: JRD at T+1, JCAP at T+2; `MonDReg` is updated and `monitor_ready`=1 at T+3.
- Avalon latency from request seen in IDLE at cycle C:
  - Write: completes at C+1 (one stall cycle).
  - Read: data at C+2 (two stall cycles).
- Worst-case JTAG wait behind one Avalon read: 2 extra cycles, by round-robin.
- A strobe arriving in the cycle `jpend` clears is accepted (no error). `jpend` clear and set compute in the same cycle.
- Reset asserted mid-access aborts immediately. The pending command is lost; `mem_rd`/`mem_wr` drop asynchronously.

## Test plan
- Reset, then `take_action_ocimem_a` with `jdo[24:17]`=0x10 and `jdo[34]`=1. RAM[0x10]=0xDEADBEEF → `MonDReg`=0xDEADBEEF at T+3, `MonAReg`=0x11, `monitor_ready` 0→1.
- `take_action_ocimem_b` with `jdo[34:3]`=0x12345678 at `MonAReg`=0xFF (ADDR_W=8) → `mem_wr` at addr 0xFF with 0x12345678; `MonAReg` wraps to 0x00.
- JTAG read pending and `av_read` at 0x20 in the same cycle, with `last_j`=1 → Avalon served first (data at C+2); JTAG read follows immediately; both return correct data.
- Second strobe one cycle after a read strobe, while `jpend`=1 → dropped, `monitor_error`=1, `MonAReg` unchanged. A later `take_action_ocimem_a` with `jdo[35]`=1 clears the error.
- Back-to-back Avalon writes to 0x00..0x03 with no JTAG traffic → each completes in 2 cycles, `av_waitrequest` low exactly one cycle per write; RAM holds the written values.
- `reset_n` pulsed low during JRD → `mem_rd`=0 immediately; after release, `monitor_ready`=1, `jpend`=0, `MonDReg`=0.
